sram_bank_access_ctrl: RTL and testbench

- Controller in front of one single-port, two-bank interleaved LUTRAM page memory (synchronous write, 1-cycle registered read, per-word read strobe).
- Sequences the preload of all compression-pattern pages from a streaming source.
- After preload, shares the memory's single access port between two read requesters using round-robin arbitration.
- Returns the selected word, tagged with the requester ID.

---
 rtl/sram_bank_access_ctrl.sv | 146 ++++++++++++++
 tb/tb_sram_bank_access_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bank_access_ctrl.sv
// Access controller for a two-bank interleaved page memory: sequences the page
// preload from a stream, then round-robins the single read port between two requesters.
module sram_bank_access_ctrl #(
  parameter int QUAN_SIZE       = 3,
  parameter int PAGE_NUM        = 8,
  parameter int BANK_INTERLEAVE = 2,
  parameter int ADDR_BITWIDTH   = 3
) (
  input  logic                                 sys_clk,
  input  logic                                 sys_rst_n,
  input  logic                                 preload_start_i,
  input  logic [QUAN_SIZE*BANK_INTERLEAVE-1:0] preload_data_i,
  input  logic                                 preload_valid_i,
  output logic                                 preload_ready_o,
  output logic                                 preload_done_o,
  input  logic [1:0]                           rd_req_i,
  input  logic [ADDR_BITWIDTH-1:0]             rd_addr0_i,
  input  logic [ADDR_BITWIDTH-1:0]             rd_addr1_i,
  input  logic                                 rd_sel0_i,
  input  logic                                 rd_sel1_i,
  output logic [1:0]                           rd_gnt_o,
  output logic                                 rd_valid_o,
  output logic                                 rd_id_o,
  output logic [QUAN_SIZE-1:0]                 rd_word_o,
  output logic [ADDR_BITWIDTH-1:0]             mem_addr_o,
  output logic                                 mem_we_o,
  output logic [QUAN_SIZE*BANK_INTERLEAVE-1:0] mem_wdata_o,
  output logic                                 mem_read_strobe_o,
  input  logic [QUAN_SIZE-1:0]                 mem_read_word_i
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRELOAD = 2'd1,
    SERVE   = 2'd2
  } state_t;

  localparam logic [ADDR_BITWIDTH-1:0] LAST_PAGE = ADDR_BITWIDTH'(PAGE_NUM - 1);

  state_t                   state;
  logic [ADDR_BITWIDTH-1:0] page_cnt;
  logic                     done_q;
  logic                     last_id;
  logic                     rsp_valid;
  logic                     rsp_id;
  logic                     rsp_sel;

  logic [1:0]               gnt;
  logic                     gnt_sel;
  logic                     beat;
  logic                     last_beat;

  assign beat      = (state == PRELOAD) && preload_valid_i;
  assign last_beat = beat && (page_cnt == LAST_PAGE);

  // Round-robin: a lone requester always wins; on contention the one not
  // served last goes first. last_id resets to 1 so requester 0 is favoured.
  always_comb begin
    // NOTE: default first, so no branch of the case can leave a latch behind.
    gnt = 2'b00;
    if (state == SERVE) begin
      case (rd_req_i)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_id ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign gnt_sel = gnt[1] ? rd_sel1_i : rd_sel0_i;

  always_comb begin
    mem_addr_o = '0;
    if (state == PRELOAD) begin
      mem_addr_o = page_cnt;
    end else if (gnt[0]) begin
      mem_addr_o = rd_addr0_i;
    end else if (gnt[1]) begin
      mem_addr_o = rd_addr1_i;
    end
  end

  assign mem_we_o        = beat;
  assign mem_wdata_o     = (state == PRELOAD) ? preload_data_i : '0;
  assign preload_ready_o = (state == PRELOAD);
  assign preload_done_o  = done_q;
  assign rd_gnt_o        = gnt;

  // The memory's output register holds the page addressed in the grant cycle;
  // the word strobe is applied one cycle later, together with the response.
  assign rd_valid_o        = rsp_valid;
  assign rd_id_o           = rsp_valid & rsp_id;
  assign mem_read_strobe_o = rsp_valid & rsp_sel;
  assign rd_word_o         = rsp_valid ? mem_read_word_i : '0;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      page_cnt  <= '0;
      done_q    <= 1'b0;
      last_id   <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_sel   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates keep every register sampling pre-edge values.
      rsp_valid <= |gnt;
      if (|gnt) begin
        rsp_id  <= gnt[1];
        rsp_sel <= gnt_sel;
        last_id <= gnt[1];
      end

      case (state)
        IDLE: begin
          if (preload_start_i) begin
            state    <= PRELOAD;
            page_cnt <= '0;
            done_q   <= 1'b0;
          end
        end
        PRELOAD: begin
          if (beat) begin
            page_cnt <= last_beat ? '0 : page_cnt + ADDR_BITWIDTH'(1);
          end
          if (last_beat) begin
            state  <= SERVE;
            done_q <= 1'b1;
          end
        end
        SERVE: begin
          // A grant issued alongside the restart still gets its response,
          // since rsp_valid was loaded above independently of the state.
          if (preload_start_i) begin
            state    <= PRELOAD;
            page_cnt <= '0;
            done_q   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bank_access_ctrl.sv
// Directed-plus-random bench for sram_bank_access_ctrl with a page-memory model
// and a reference model of preload contents, arbitration order and responses.
module tb_sram_bank_access_ctrl;

  localparam int QW = 3;
  localparam int WW = 6;
  localparam int AW = 3;
  localparam int PN = 8;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          preload_start;
  logic [WW-1:0] preload_data;
  logic          preload_valid;
  logic          preload_ready;
  logic          preload_done;
  logic [1:0]    rd_req;
  logic [AW-1:0] rd_addr0;
  logic [AW-1:0] rd_addr1;
  logic          rd_sel0;
  logic          rd_sel1;
  logic [1:0]    rd_gnt;
  logic          rd_valid;
  logic          rd_id;
  logic [QW-1:0] rd_word;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [WW-1:0] mem_wdata;
  logic          mem_read_strobe;
  logic [QW-1:0] mem_read_word;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [WW-1:0] page_ref [PN];
  logic [WW-1:0] pdata    [PN];
  logic          in_serve;
  logic          last_id;
  logic          exp_v;
  logic          exp_id;
  logic          exp_sel;
  logic [QW-1:0] exp_word;

  // Page memory: synchronous write, registered page read, combinational word select
  logic [WW-1:0] mem [PN];
  logic [WW-1:0] mem_rd_q;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rd_q <= mem[mem_addr];
  end

  assign mem_read_word = mem_read_strobe ? mem_rd_q[QW-1:0] : mem_rd_q[WW-1:QW];

  sram_bank_access_ctrl dut (
    .sys_clk           (clk),
    .sys_rst_n         (rst_n),
    .preload_start_i   (preload_start),
    .preload_data_i    (preload_data),
    .preload_valid_i   (preload_valid),
    .preload_ready_o   (preload_ready),
    .preload_done_o    (preload_done),
    .rd_req_i          (rd_req),
    .rd_addr0_i        (rd_addr0),
    .rd_addr1_i        (rd_addr1),
    .rd_sel0_i         (rd_sel0),
    .rd_sel1_i         (rd_sel1),
    .rd_gnt_o          (rd_gnt),
    .rd_valid_o        (rd_valid),
    .rd_id_o           (rd_id),
    .rd_word_o         (rd_word),
    .mem_addr_o        (mem_addr),
    .mem_we_o          (mem_we),
    .mem_wdata_o       (mem_wdata),
    .mem_read_strobe_o (mem_read_strobe),
    .mem_read_word_i   (mem_read_word)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ready"},  8'(preload_ready),   8'd0);
    chk({tag, "_done"},   8'(preload_done),    8'd0);
    chk({tag, "_gnt"},    8'(rd_gnt),          8'd0);
    chk({tag, "_valid"},  8'(rd_valid),        8'd0);
    chk({tag, "_id"},     8'(rd_id),           8'd0);
    chk({tag, "_we"},     8'(mem_we),          8'd0);
    chk({tag, "_addr"},   8'(mem_addr),        8'd0);
    chk({tag, "_strobe"}, 8'(mem_read_strobe), 8'd0);
    chk({tag, "_word"},   8'(rd_word),         8'd0);
  endtask

  task automatic check_response();
    chk("rd_valid",  8'(rd_valid),        8'(exp_v));
    chk("rd_word",   8'(rd_word),         exp_v ? 8'(exp_word) : 8'd0);
    chk("rd_strobe", 8'(mem_read_strobe), exp_v ? 8'(exp_sel)  : 8'd0);
    if (exp_v) chk("rd_id", 8'(rd_id), 8'(exp_id));
  endtask

  // One IDLE/SERVE cycle: drive, predict grant from the round-robin rule, check, advance.
  task automatic serve_cycle(input logic [1:0] req, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                             input logic s0, input logic s1, input logic start);
    logic [1:0]    eg;
    logic [AW-1:0] ga;
    logic          gs;
    rd_req        = req;
    rd_addr0      = a0;
    rd_addr1      = a1;
    rd_sel0       = s0;
    rd_sel1       = s1;
    preload_start = start;
    preload_valid = 1'b0;
    eg = 2'b00;
    if (in_serve) begin
      if (req == 2'b01 || (req == 2'b11 && last_id == 1'b1)) eg = 2'b01;
      else if (req != 2'b00) eg = 2'b10;
    end
    ga = eg[1] ? a1 : a0;
    gs = eg[1] ? s1 : s0;
    @(negedge clk);
    chk("gnt",      8'(rd_gnt),       8'(eg));
    chk("mem_addr", 8'(mem_addr),     (eg != 2'b00) ? 8'(ga) : 8'd0);
    chk("mem_we",   8'(mem_we),       8'd0);
    chk("done",     8'(preload_done), 8'(in_serve));
    check_response();
    tick();
    exp_v = (eg != 2'b00);
    if (exp_v) begin
      exp_id   = eg[1];
      exp_sel  = gs;
      exp_word = gs ? page_ref[ga][QW-1:0] : page_ref[ga][WW-1:QW];
      last_id  = eg[1];
    end
    if (start) in_serve = 1'b0;
    preload_start = 1'b0;
  endtask

  task automatic rand_serve(input logic [1:0] req);
    serve_cycle(req, 3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'b0);
  endtask

  // Streams pdata into the controller (already in PRELOAD); bub marks stall cycles.
  task automatic preload(input logic [63:0] bub, input int exp_cycles);
    int   k = 0;
    int   cyc = 0;
    logic v;
    while (k < PN && cyc < 40) begin
      v             = ~bub[cyc];
      preload_valid = v;
      preload_data  = pdata[k];
      preload_start = (cyc == 1);
      rd_req        = 2'b11;
      rd_addr0      = 3'($urandom);
      rd_addr1      = 3'($urandom);
      @(negedge clk);
      chk("pl_ready", 8'(preload_ready), 8'd1);
      chk("pl_we",    8'(mem_we),        8'(v));
      chk("pl_addr",  8'(mem_addr),      8'(k));
      chk("pl_wdata", 8'(mem_wdata),     8'(pdata[k]));
      chk("pl_done",  8'(preload_done),  8'd0);
      chk("pl_gnt",   8'(rd_gnt),        8'd0);
      check_response();
      tick();
      exp_v = 1'b0;
      if (v) begin
        page_ref[k] = pdata[k];
        k++;
      end
      cyc++;
    end
    preload_valid = 1'b0;
    preload_start = 1'b0;
    rd_req        = 2'b00;
    in_serve      = 1'b1;
    chk("pl_cycles", 8'(cyc), 8'(exp_cycles));
    @(negedge clk);
    chk("pl_done_set",  8'(preload_done),  8'd1);
    chk("pl_ready_clr", 8'(preload_ready), 8'd0);
    chk("pl_we_clr",    8'(mem_we),        8'd0);
    chk("pl_gnt_idle",  8'(rd_gnt),        8'd0);
    check_response();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    preload_start = 1'b0;
    preload_valid = 1'b0;
    preload_data  = '0;
    rd_req        = 2'b00;
    rd_addr0      = '0;
    rd_addr1      = '0;
    rd_sel0       = 1'b0;
    rd_sel1       = 1'b0;
    in_serve      = 1'b0;
    last_id       = 1'b1;
    exp_v         = 1'b0;
    exp_id        = 1'b0;
    exp_sel       = 1'b0;
    exp_word      = '0;

    #1 rst_n = 1'b0;
    #2 check_reset("rst");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Start from IDLE with both requesters asking: no grant, then 8 straight beats
    serve_cycle(2'b11, 3'd1, 3'd2, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < PN; i++) pdata[i] = 6'(i);
    preload(64'd0, 8);

    // Re-preload with stalls on cycles 3 and 5
    for (int i = 0; i < PN; i++) pdata[i] = 6'($urandom);
    pdata[5] = 6'b101_011;
    serve_cycle(2'b00, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    preload(64'h28, 10);

    // Contention from a fresh pointer: 01, 10, 01, 10
    repeat (4) rand_serve(2'b11);
    rand_serve(2'b00);

    // Single read of page 5, lower word
    serve_cycle(2'b01, 3'd5, 3'd0, 1'b1, 1'b0, 1'b0);
    serve_cycle(2'b00, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);

    // Random request traffic
    repeat (60) rand_serve(2'($urandom));

    // Restart while granting requester 1; its response must still appear
    serve_cycle(2'b10, 3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    for (int i = 0; i < PN; i++) pdata[i] = 6'($urandom);
    preload(64'd0, 8);
    repeat (10) rand_serve(2'($urandom));

    // Reset after 4 preload beats
    serve_cycle(2'b00, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      preload_valid = 1'b1;
      preload_data  = 6'($urandom);
      rd_req        = 2'b11;
      tick();
      page_ref[i] = preload_data;
    end
    #2 rst_n = 1'b0;
    #1 check_reset("mid_rst");
    in_serve = 1'b0;
    last_id  = 1'b1;
    exp_v    = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    preload_valid = 1'b0;
    repeat (3) rand_serve(2'b11);
    for (int i = 0; i < PN; i++) pdata[i] = 6'($urandom);
    serve_cycle(2'b11, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    preload(64'd0, 8);
    repeat (6) rand_serve(2'b11);
    repeat (10) rand_serve(2'($urandom));
    rand_serve(2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
